// File: rtl/gated_event_counter_pkg.sv
// Shared definitions for gated_event_counter: state encoding and hold counter width.
package gated_event_counter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_SAT   = 2'd3;

  // Width of the post-disarm hold counter (HOLD_CYCLES is limited to 1..255).
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    HOLD  = ST_HOLD,
    SAT   = ST_SAT
  } state_t;

endpackage

// File: rtl/data_edge_detect.sv
// Registers the previous data sample and produces the qualifying-event strobe.
// Build option GATED_EVENT_COUNTER_EDGE_EN: defined = rising edges only,
// undefined = every cycle with data high.
module data_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic data,
  output logic evt
);

  logic data_q;

  // One-cycle delayed copy of data, updated every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= 1'b0;
    else        data_q <= data;
  end

`ifdef GATED_EVENT_COUNTER_EDGE_EN
  assign evt = data & ~data_q;
`else
  // Level mode: data_q is kept so both builds share the same register set,
  // but it does not take part in qualification.
  logic unused_data_q;
  assign unused_data_q = data_q;
  assign evt = data;
`endif

endmodule

// File: rtl/gated_event_counter.sv
// Gated event counter: counts qualifying events on data while an arm/hold
// window is open, saturates at all-ones, and pulses valid when a window
// closes normally. Edge/level qualification is selected by the
// GATED_EVENT_COUNTER_EDGE_EN macro inside data_edge_detect.
// Output semantics: valid is a single-cycle strobe (no ready/backpressure);
// it is high for exactly the cycle after the HOLD-to-IDLE edge and count is
// stable while it is high.
module gated_event_counter
  import gated_event_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data,
  input  logic             arm,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             gate,
  output logic             sat,
  output logic             valid
);

  localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0]  MAX       = {WIDTH{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  count_d;
  logic              gate_d, sat_d, valid_d;
  logic              evt;
  logic              hits_max;

  data_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .evt   (evt)
  );

  // A qualifying event that would bring the count to all-ones.
  assign hits_max = evt && (count == (MAX - ONE));

  // Next-state, next-count and registered-output decode; clear overrides all.
  always_comb begin
    state_d = state_q;
    count_d = count;
    hold_d  = hold_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            count_d = '0;
          end
        end
        ARMED: begin
          if (evt) count_d = count + ONE;
          if (hits_max) begin
            state_d = SAT;
          end else if (!arm) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (evt) count_d = count + ONE;
          if (hits_max) begin
            state_d = SAT;
          end else if (arm) begin
            state_d = ARMED;
          end else if (hold_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        SAT: begin
          state_d = SAT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    gate_d = (state_d == ARMED) || (state_d == HOLD);
    sat_d  = (state_d == SAT);
  end

  // State, counters and all outputs are registered from the decoded next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count   <= '0;
      gate    <= 1'b0;
      sat     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count   <= count_d;
      gate    <= gate_d;
      sat     <= sat_d;
      valid   <= valid_d;
    end
  end

endmodule

// File: tb/tb_gated_event_counter.sv
// Self-checking bench for gated_event_counter: a WIDTH=8 instance driven from
// a vector table through an expected-value queue, plus a WIDTH=4 instance for
// saturation, and hand sequences for level/edge mode and async reset.
module tb_gated_event_counter;

  logic       clk;
  logic       rst_n;
  logic       data8, arm8, clear8;
  logic [7:0] count8;
  logic       gate8, sat8, valid8;
  logic       data4, arm4, clear4;
  logic [3:0] count4;
  logic       gate4, sat4, valid4;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {count, gate, sat, valid} for the WIDTH=8 instance.
  logic [10:0] exp_q[$];

  typedef struct {
    logic       arm;
    logic       data;
    logic       clear;
    logic [7:0] count;
    logic       gate;
    logic       sat;
    logic       valid;
  } vec_t;

  vec_t tbl[$];

  gated_event_counter #(.WIDTH(8), .HOLD_CYCLES(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data8),
    .arm   (arm8),
    .clear (clear8),
    .count (count8),
    .gate  (gate8),
    .sat   (sat8),
    .valid (valid8)
  );

  gated_event_counter #(.WIDTH(4), .HOLD_CYCLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data4),
    .arm   (arm4),
    .clear (clear4),
    .count (count4),
    .gate  (gate4),
    .sat   (sat4),
    .valid (valid4)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, return 1 time unit after the next rising edge.
  task automatic cyc8(input logic a, input logic d, input logic c);
    @(negedge clk);
    arm8 = a; data8 = d; clear8 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic a, input logic d, input logic c);
    @(negedge clk);
    arm4 = a; data4 = d; clear4 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic a, input logic d, input logic c,
                     input logic [7:0] cnt, input logic g, input logic s, input logic v);
    vec_t r;
    r.arm = a; r.data = d; r.clear = c;
    r.count = cnt; r.gate = g; r.sat = s; r.valid = v;
    tbl.push_back(r);
  endtask

  initial begin
    logic [10:0] exp_v;
    logic [7:0]  level_exp;

    rst_n = 1'b0;
    data8 = 1'b0; arm8 = 1'b0; clear8 = 1'b0;
    data4 = 1'b0; arm4 = 1'b0; clear4 = 1'b0;

    // Reset only: data toggles while rst_n is held low.
    for (int i = 0; i < 4; i++) begin
      cyc8(1'b1, i[0], 1'b0);
      check("reset_hold", {count8, gate8, sat8, valid8}, 11'h0);
    end
    @(negedge clk);
    arm8 = 1'b0; data8 = 1'b0;
    rst_n = 1'b1;

    // Basic window, late event in HOLD, arm falling with an event, re-arm, clear.
    //  arm  data clr  count  gate sat valid
    add(0, 0, 0, 8'd0, 0, 0, 0);
    add(0, 1, 0, 8'd0, 0, 0, 0);
    add(1, 0, 0, 8'd0, 1, 0, 0);
    add(1, 1, 0, 8'd1, 1, 0, 0);
    add(1, 0, 0, 8'd1, 1, 0, 0);
    add(1, 1, 0, 8'd2, 1, 0, 0);
    add(1, 0, 0, 8'd2, 1, 0, 0);
    add(1, 0, 0, 8'd2, 1, 0, 0);
    add(1, 1, 0, 8'd3, 1, 0, 0);
    add(1, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 0, 0, 1);
    add(0, 0, 0, 8'd3, 0, 0, 0);
    add(1, 0, 0, 8'd0, 1, 0, 0);
    add(1, 1, 0, 8'd1, 1, 0, 0);
    add(1, 0, 0, 8'd1, 1, 0, 0);
    add(1, 1, 0, 8'd2, 1, 0, 0);
    add(1, 0, 0, 8'd2, 1, 0, 0);
    add(1, 1, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 0, 0, 8'd3, 1, 0, 0);
    add(0, 1, 0, 8'd4, 1, 0, 0);
    add(0, 0, 0, 8'd4, 1, 0, 0);
    add(0, 0, 0, 8'd4, 0, 0, 1);
    add(0, 0, 0, 8'd4, 0, 0, 0);
    add(1, 0, 0, 8'd0, 1, 0, 0);
    add(0, 1, 0, 8'd1, 1, 0, 0);
    add(0, 0, 0, 8'd1, 1, 0, 0);
    add(1, 0, 0, 8'd1, 1, 0, 0);
    add(1, 0, 0, 8'd1, 1, 0, 0);
    add(0, 0, 0, 8'd1, 1, 0, 0);
    add(0, 0, 1, 8'd0, 0, 0, 0);
    add(0, 0, 0, 8'd0, 0, 0, 0);

    foreach (tbl[i]) begin
      exp_q.push_back({tbl[i].count, tbl[i].gate, tbl[i].sat, tbl[i].valid});
      cyc8(tbl[i].arm, tbl[i].data, tbl[i].clear);
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d", i), {count8, gate8, sat8, valid8}, exp_v);
    end

    // Level vs edge: data held high for 5 armed cycles.
`ifdef GATED_EVENT_COUNTER_EDGE_EN
    level_exp = 8'd1;
`else
    level_exp = 8'd5;
`endif
    cyc8(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc8(1'b1, 1'b1, 1'b0);
    cyc8(1'b1, 1'b0, 1'b0);
    check("level_count", count8, level_exp);
    cyc8(1'b0, 1'b0, 1'b1);

    // Saturation on the 4-bit instance.
    cyc4(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc4(1'b1, 1'b1, 1'b0);
      if (k == 13) check("sat_pre14", {count4, gate4, sat4}, {4'd14, 1'b1, 1'b0});
      if (k == 14) check("sat_hit15", {count4, gate4, sat4}, {4'd15, 1'b0, 1'b1});
      cyc4(1'b1, 1'b0, 1'b0);
    end
    check("sat_after16", {count4, gate4, sat4, valid4}, {4'd15, 1'b0, 1'b1, 1'b0});
    cyc4(1'b0, 1'b1, 1'b0);
    cyc4(1'b1, 1'b0, 1'b0);
    cyc4(1'b0, 1'b1, 1'b0);
    cyc4(1'b1, 1'b1, 1'b0);
    cyc4(1'b0, 1'b0, 1'b0);
    check("sat_frozen", {count4, gate4, sat4, valid4}, {4'd15, 1'b0, 1'b1, 1'b0});
    cyc4(1'b0, 1'b0, 1'b1);
    check("sat_clear", {count4, gate4, sat4, valid4}, 7'h0);

    // Saturating event in the same cycle as arm falling goes to SAT, not HOLD.
    cyc4(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      cyc4(1'b1, 1'b1, 1'b0);
      cyc4(1'b1, 1'b0, 1'b0);
    end
    check("sat_arm_pre", count4, 4'd14);
    cyc4(1'b0, 1'b1, 1'b0);
    check("sat_arm_fall", {count4, gate4, sat4, valid4}, {4'd15, 1'b0, 1'b1, 1'b0});
    for (int k = 0; k < 6; k++) begin
      cyc4(1'b0, 1'b0, 1'b0);
      check("sat_no_valid", {valid4, sat4}, 2'b01);
    end
    cyc4(1'b0, 1'b0, 1'b1);

    // Async reset in HOLD with count=7.
    cyc8(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc8(1'b1, 1'b1, 1'b0);
      cyc8(1'b1, 1'b0, 1'b0);
    end
    cyc8(1'b0, 1'b0, 1'b0);
    check("hold_pre_reset", {count8, gate8, sat8, valid8}, {8'd7, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {count8, gate8, sat8, valid8}, 11'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc8(1'b0, 1'b0, 1'b0);
    check("post_reset_idle", {count8, gate8, sat8, valid8}, 11'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
